proc_control_fsm: RTL

- Multi-cycle control unit for the 8-bit processor.
- Sequences each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
- Drives the PC, instruction register, register file, ALU and data-memory enables.
- Consumes the 3-bit opcode produced by instruction decode, the ALU zero flag and a data-memory ready handshake.

---
 rtl/proc_pkg.sv | 41 ++++
 rtl/proc_ctrl_outdec.sv | 37 +++
 rtl/proc_control_fsm.sv | 74 +++++++
 3 files changed

// File: rtl/proc_pkg.sv
// proc_pkg: shared opcode, state, ALU and PC-source codes plus the control vector type
package proc_pkg;
    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_ADDI  = 3'd2;
    localparam logic [2:0] OP_LOAD  = 3'd3;
    localparam logic [2:0] OP_STORE = 3'd4;
    localparam logic [2:0] OP_BEQ   = 3'd5;
    localparam logic [2:0] OP_JMP   = 3'd6;
    localparam logic [2:0] OP_HALT  = 3'd7;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_SUB  = 2'd1;
    localparam logic [1:0] ALU_PASS = 2'd2;

    localparam logic [1:0] PCSRC_INC = 2'd0;
    localparam logic [1:0] PCSRC_BR  = 2'd1;
    localparam logic [1:0] PCSRC_JMP = 2'd2;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] alu_op;
        logic       alu_src_imm;
        logic       wb_from_mem;
        logic       halted;
    } ctrl_t;
endpackage

// File: rtl/proc_ctrl_outdec.sv
// proc_ctrl_outdec: combinational state + latched opcode to control-vector decoder
module proc_ctrl_outdec
    import proc_pkg::*;
(
    input  state_t     state,
    input  logic [2:0] op,
    input  logic       alu_zero,
    output ctrl_t      ctrl
);
    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.ir_write = 1'b1;
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_INC;
            end
            ST_EXEC: begin
                ctrl.alu_op      = (op == OP_SUB || op == OP_BEQ) ? ALU_SUB : ALU_ADD;
                ctrl.alu_src_imm = op inside {OP_ADDI, OP_LOAD, OP_STORE};
                ctrl.pc_write    = (op == OP_JMP) || (op == OP_BEQ && alu_zero);
                ctrl.pc_src      = (op == OP_JMP) ? PCSRC_JMP :
                                   (op == OP_BEQ && alu_zero) ? PCSRC_BR : PCSRC_INC;
            end
            ST_MEM: begin
                ctrl.mem_read  = op == OP_LOAD;
                ctrl.mem_write = op == OP_STORE;
            end
            ST_WB: begin
                ctrl.reg_write   = 1'b1;
                ctrl.wb_from_mem = op == OP_LOAD;
            end
            ST_HALT: ctrl.halted = 1'b1;
            default: ctrl = '0;
        endcase
    end
endmodule

// File: rtl/proc_control_fsm.sv
// proc_control_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit for the 8-bit processor
module proc_control_fsm
    import proc_pkg::*;
#(
    parameter int OPW    = 3,
    parameter int ALUOPW = 2,
    parameter int STW    = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [OPW-1:0]    opcode,
    input  logic              alu_zero,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic [1:0]        pc_src,
    output logic              ir_write,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ALUOPW-1:0] alu_op,
    output logic              alu_src_imm,
    output logic              wb_from_mem,
    output logic              halted,
    output logic [STW-1:0]    state_dbg
);
    state_t         state, nxt;
    logic [OPW-1:0] op_q;
    ctrl_t          ctrl, co;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_FETCH;
            op_q  <= '0;
        end else begin
            state <= nxt;
            if (state == ST_DECODE) op_q <= opcode;
        end
    end

    always_comb begin
        nxt = ST_FETCH;
        case (state)
            ST_FETCH:  nxt = ST_DECODE;
            ST_DECODE: nxt = (opcode == OP_HALT) ? ST_HALT : ST_EXEC;
            ST_EXEC:   nxt = (op_q inside {OP_LOAD, OP_STORE}) ? ST_MEM :
                             (op_q inside {OP_BEQ, OP_JMP, OP_HALT}) ? ST_FETCH : ST_WB;
            ST_MEM:    nxt = !mem_ready ? ST_MEM : (op_q == OP_LOAD) ? ST_WB : ST_FETCH;
            ST_WB:     nxt = ST_FETCH;
            ST_HALT:   nxt = ST_HALT;
            default:   nxt = ST_FETCH;
        endcase
    end

    proc_ctrl_outdec u_outdec (
        .state    (state),
        .op       (op_q),
        .alu_zero (alu_zero),
        .ctrl     (ctrl)
    );

    // Reset masks every output combinationally so an abandoned instruction never strobes.
    assign co          = reset ? ctrl : '0;
    assign pc_write    = co.pc_write;
    assign pc_src      = co.pc_src;
    assign ir_write    = co.ir_write;
    assign reg_write   = co.reg_write;
    assign mem_read    = co.mem_read;
    assign mem_write   = co.mem_write;
    assign alu_op      = co.alu_op;
    assign alu_src_imm = co.alu_src_imm;
    assign wb_from_mem = co.wb_from_mem;
    assign halted      = co.halted;
    assign state_dbg   = reset ? state : '0;
endmodule
